iterative_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle execute ALU; sits in the EX stage.
- Single-cycle ops: adds XOR, shifts and set-less-than, and fixes signed branch compares.
- Multi-cycle ops: RV32M multiply/divide/remainder as iterative radix-2 units.
- Pipeline connects through valid/ready on both sides; a held result stalls the input side.

---
 rtl/iterative_alu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// iterative_alu: EX-stage ALU with valid/ready handshake; iterative RV32M mul/div when ITER_ALU_MULDIV_EN is defined
module iterative_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      ALUControl,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] resultALU,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] result_q, result_d, alu_res;
    logic zero_q, zero_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic accept, upd, eq, lt_s, lt_u;
    logic [SHW-1:0] shamt;
    assign shamt = operand2[SHW-1:0];
    assign accept = inValid & in_ready_q;
    assign eq = operand1 == operand2;
    assign lt_s = $signed(operand1) < $signed(operand2);
    assign lt_u = operand1 < operand2;
    assign inReady = in_ready_q;
    assign outValid = out_valid_q;
    assign resultALU = result_q;
    assign zero = zero_q;
    always_comb begin
        alu_res = operand1 + operand2;
        case (ALUControl)
            5'b00000: alu_res = operand1 & operand2;
            5'b00001: alu_res = operand1 | operand2;
            5'b00011: alu_res = operand1 ^ operand2;
            5'b00100: alu_res = operand1 << shamt;
            5'b00101: alu_res = operand1 >> shamt;
            5'b00110: alu_res = operand1 - operand2;
            5'b00111: alu_res = $signed(operand1) >>> shamt;
            5'b01000: alu_res = {{(XLEN-1){1'b0}}, ~eq};
            5'b01001: alu_res = {{(XLEN-1){1'b0}}, eq};
            5'b01010: alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
            5'b01011: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            5'b01100: alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
            5'b01101: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            5'b01110: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            5'b01111: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            default:  alu_res = operand1 + operand2;
        endcase
    end
`ifdef ITER_ALU_MULDIV_EN
    localparam logic [XLEN-1:0] min_val = {1'b1, {(XLEN-1){1'b0}}};
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, ma, mb, hi_nx, lo_nx, fix_res;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic neg_q, neg_d, busy_q, busy_d, sa, sb;
    logic [XLEN:0] mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod;
    assign sa = operand1[XLEN-1] & (ALUControl[2] ? ~ALUControl[0] : ALUControl[1:0] != 2'b11);
    assign sb = operand2[XLEN-1] & ~(ALUControl[2] ? ALUControl[0] : ALUControl[1]);
    assign ma = sa ? -operand1 : operand1;
    assign mb = sb ? -operand2 : operand2;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign div_sh = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    assign hi_nx = state_q == MUL ? mul_sum[XLEN:1] : (div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]);
    assign lo_nx = state_q == MUL ? {mul_sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    // sign fix-up is folded into the last iteration so the result lands XLEN cycles after entering MUL/DIV
    assign prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    assign fix_res = op_q[2] ? (op_q[1] ? (neg_q ? -hi_nx : hi_nx) : (neg_q ? -lo_nx : lo_nx))
                             : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        result_d = result_q;
        out_valid_d = out_valid_q;
        upd = 1'b0;
`ifdef ITER_ALU_MULDIV_EN
        hi_d = hi_q;
        lo_d = lo_q;
        m_d = m_q;
        cnt_d = cnt_q;
        op_d = op_q;
        neg_d = neg_q;
`endif
        if (accept) begin
            state_d = DONE;
            out_valid_d = 1'b1;
            result_d = alu_res;
            upd = 1'b1;
`ifdef ITER_ALU_MULDIV_EN
            if (ALUControl[4:3] == 2'b10) begin
                hi_d = '0;
                lo_d = ALUControl[2] ? ma : mb;
                m_d = ALUControl[2] ? mb : ma;
                cnt_d = '0;
                op_d = ALUControl[2:0];
                neg_d = (ALUControl[2] & ALUControl[1]) ? sa : sa ^ sb;
                if (ALUControl[2] && operand2 == '0)
                    result_d = ALUControl[1] ? operand1 : '1;
                else if (ALUControl[2] && !ALUControl[0] && operand1 == min_val && operand2 == '1)
                    result_d = ALUControl[1] ? '0 : min_val;
                else begin
                    state_d = ALUControl[2] ? DIV : MUL;
                    out_valid_d = 1'b0;
                    result_d = result_q;
                    upd = 1'b0;
                end
            end
`else
            if (ALUControl[4:3] == 2'b10)
                result_d = '0;
`endif
        end else if (out_valid_q && outReady) begin
            state_d = IDLE;
            out_valid_d = 1'b0;
        end
`ifdef ITER_ALU_MULDIV_EN
        else if (state_q == MUL || state_q == DIV) begin
            hi_d = hi_nx;
            lo_d = lo_nx;
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = DONE;
                out_valid_d = 1'b1;
                result_d = fix_res;
                upd = 1'b1;
            end
        end
        busy_d = state_d == MUL || state_d == DIV;
`endif
        zero_d = upd ? result_d == '0 : zero_q;
        in_ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            result_q <= '0;
            zero_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef ITER_ALU_MULDIV_EN
            hi_q <= '0;
            lo_q <= '0;
            m_q <= '0;
            cnt_q <= '0;
            op_q <= '0;
            neg_q <= 1'b0;
            busy_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            result_q <= result_d;
            zero_q <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q <= in_ready_d;
`ifdef ITER_ALU_MULDIV_EN
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q <= m_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            neg_q <= neg_d;
            busy_q <= busy_d;
`endif
        end
    end
endmodule
